uart_tx: RTL

Serial UART transmitter for the low-power multi-clock system: the transmit end of the UART link whose receive end delivers P_DATA/data_valid. It accepts one parallel byte per handshake, frames it as start bit, LSB-first data, optional parity and stop bit, and drives TX_OUT at one bit per clk cycle. clk is the already-divided UART TX clock, so there is no oversampling or prescale. In the system it sits behind the TX synchronizer/FIFO read side, which watches busy to pace transfers.

---
 rtl/uart_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one line bit per clk edge.
// Frame = start(0), data LSB first, optional parity, stop(1).
// A request is taken only in IDLE. P_DATA, PAR_EN and PAR_TYP are latched at
// that handshake, so the frame never sees later changes to them.
module uart_tx #(
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned CNT_W = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(data_width - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic [data_width-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_bit;

  // Parity comes from the latched byte: even = XOR of data, odd = inverted XOR.
  assign par_bit = (^data_q) ^ par_typ_q;

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          state_d   = START;
          shift_d   = P_DATA;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          cnt_d     = '0;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? PARITY : STOP;
          cnt_d   = '0;
        end else begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line and busy are decoded from the upcoming state so that both come
  // straight out of flops in the same cycle the state takes effect.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
      PARITY: tx_d = par_bit;
      STOP:   tx_d = 1'b1;
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
